control_temperatura: RTL and testbench
======================================

Name: control_temperatura

Overview:
Sampling scheduler and thermal decision controller for the temperature-monitoring datapath. It periodically issues read requests (lect / en_m1) to the measurement unit, collects four 5-bit temperatura samples, and averages them. It applies hysteresis thresholds to drive est_ventilador and est_alarma and reports the system state on estados. A sensor-timeout watchdog forces a fail-safe state.

Parameters:
PERIODO_MUESTRA, 16, clock cycles in ESPERA between the end of one read and the next lect assertion (>=2)
TIMEOUT, 8, max cycles lect may stay high without temp_valida before sensor fault (>=2)
UMBRAL_VENT, 20, fan turn-on threshold (average temperature, 5-bit)
UMBRAL_ALARMA, 28, alarm turn-on threshold (> UMBRAL_VENT)
HISTERESIS, 2, turn-off margin below each threshold (<= UMBRAL_VENT)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
en_sist  in  1  system enable
temperatura  in  5  sensor sample, valid when temp_valida=1
temp_valida  in  1  sample-valid acknowledge from measurement unit
lect  out  1  read request to measurement unit
en_m1  out  1  measurement unit enable
temp_prom  out  5  last completed 4-sample average
est_ventilador  out  1  fan on
est_alarma  out  1  alarm on
err_sensor  out  1  sensor timeout fault flag
estados  out  2  00 normal, 01 fan, 10 alarm, 11 sensor fault

Behaviour:
- Reset (reset=0 at a rising edge) takes priority over everything, including mid-read.
  - All outputs go to 0.
  - FSM goes to REPOSO; timer, timeout counter, sample counter and 7-bit accumulator clear.
- FSM states: REPOSO, ESPERA, LECTURA, EVALUA.
- REPOSO:
  - lect=0, en_m1=0.
  - est_ventilador, est_alarma, err_sensor, estados are forced 0; temp_prom holds.
  - Goes to ESPERA when en_sist=1.
- en_sist=0 in any state: go to REPOSO next edge. Accumulator and sample count clear, and REPOSO output rules apply from that edge.
- en_m1 = 1 in ESPERA, LECTURA and EVALUA.
- ESPERA: timer counts PERIODO_MUESTRA cycles, then LECTURA.
- LECTURA:
  - lect=1, held until temp_valida=1 is sampled or the timeout expires.
  - On a valid sample: accumulator += temperatura (7 bits, max 124); sample count +1.
  - lect=0 from the next edge.
  - If this is the 4th sample, go to EVALUA; otherwise return to ESPERA.
  - temp_valida while lect=0 is ignored.
- Average:
  - At the edge capturing the 4th sample, temp_prom = (accumulator + sample) >> 2 (truncating).
  - Accumulator and count clear.
- EVALUA (one cycle): outputs update at the edge leaving EVALUA, then the FSM returns to ESPERA.
- Latency: 4th temp_valida at edge n -> temp_prom at n+1 -> est_*/estados at n+2.
- Hysteresis on average p:
  - Alarm sets if p >= UMBRAL_ALARMA; clears if p < UMBRAL_ALARMA-HISTERESIS; otherwise holds.
  - Fan sets if p >= UMBRAL_VENT or alarm is on; clears if p < UMBRAL_VENT-HISTERESIS and alarm is off; otherwise holds.
- estados priority: err_sensor -> 11; alarm -> 10; fan -> 01; else 00.
- Timeout: if lect has been high TIMEOUT cycles with no temp_valida:
  - lect drops.
  - err_sensor=1, est_ventilador=1, est_alarma=1, estados=11 (fail-safe).
  - Accumulator and count clear; FSM returns to ESPERA.
  - temp_prom holds.
- Fault clear: err_sensor clears only at the next successful EVALUA, which recomputes the fan and alarm state from the new average.
- Simultaneous temp_valida and timeout expiry in the same cycle: the sample wins, no fault.

Test Plan:
- Reset: pulse reset=0 for 3 cycles while lect=1 -> all outputs 0 next edge; after release with en_sist=1, first lect rises after 16 ESPERA cycles.
- Normal average: four samples of 22, temp_valida one cycle after lect -> temp_prom=22, est_ventilador=1, est_alarma=0, estados=01, 2 edges after the 4th valid.
- Fan hysteresis:
  - Samples 20,21,22,23 -> temp_prom=21, fan on.
  - Then four 19 -> fan stays on (19>=18).
  - Then four 17 -> fan off, estados=00.
- Alarm hysteresis:
  - Four 30 -> estados=10, fan=1, alarm=1.
  - Four 27 -> alarm held.
  - Four 25 -> alarm off, fan on, estados=01.
- Timeout:
  - No temp_valida for 8 cycles -> lect=0, err_sensor=1, est_alarma=1, est_ventilador=1, estados=11.
  - Then four valid samples of 10 -> err_sensor=0, estados=00.
- Spurious and disable:
  - temp_valida pulse while lect=0 -> sample count unchanged, average unaffected.
  - en_sist=0 during LECTURA -> next edge lect=0, en_m1=0, estados=00.

Source files
------------

// File: rtl/control_temperatura_if.sv
// Bus between the thermal controller and the measurement unit / system side.
// Latency: none, wires only.
// Backpressure: lect stays high until temp_valida answers or the watchdog fires.
interface control_temperatura_if;
   logic       en_sist;
   logic [4:0] temperatura;
   logic       temp_valida;
   logic       lect;
   logic       en_m1;
   logic [4:0] temp_prom;
   logic       est_ventilador;
   logic       est_alarma;
   logic       err_sensor;
   logic [1:0] estados;

   // Controller side: issues reads and reports the thermal state.
   modport master (
      input  en_sist, temperatura, temp_valida,
      output lect, en_m1, temp_prom, est_ventilador, est_alarma, err_sensor, estados
   );

   // Environment side: measurement unit plus system enable.
   modport slave (
      output en_sist, temperatura, temp_valida,
      input  lect, en_m1, temp_prom, est_ventilador, est_alarma, err_sensor, estados
   );
endinterface

// File: rtl/control_temperatura.sv
// Periodic sampler: 4 reads -> average -> fan/alarm hysteresis, with a sensor watchdog.
// Latency: 4th valid sample -> temp_prom +1 edge -> est_*/estados +2 edges.
// Backpressure: lect is held until temp_valida or TIMEOUT cycles, then fail-safe.
module control_temperatura #(
   parameter int PERIODO_MUESTRA = 16,
   parameter int TIMEOUT         = 8,
   parameter int UMBRAL_VENT     = 20,
   parameter int UMBRAL_ALARMA   = 28,
   parameter int HISTERESIS      = 2
) (
   input logic                   clock,
   input logic                   reset,
   control_temperatura_if.master bus
);

   localparam logic [1:0] REPOSO  = 2'd0;
   localparam logic [1:0] ESPERA  = 2'd1;
   localparam logic [1:0] LECTURA = 2'd2;
   localparam logic [1:0] EVALUA  = 2'd3;

   localparam int TW  = (PERIODO_MUESTRA > 2) ? $clog2(PERIODO_MUESTRA) : 1;
   localparam int TOW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   localparam logic [TW-1:0]  T_FIN  = TW'(PERIODO_MUESTRA - 1);
   localparam logic [TOW-1:0] TO_FIN = TOW'(TIMEOUT - 1);

   localparam logic [4:0] A_ON  = 5'(UMBRAL_ALARMA);
   localparam logic [4:0] A_OFF = 5'(UMBRAL_ALARMA - HISTERESIS);
   localparam logic [4:0] V_ON  = 5'(UMBRAL_VENT);
   localparam logic [4:0] V_OFF = 5'(UMBRAL_VENT - HISTERESIS);

   logic [1:0]     estado;
   logic [TW-1:0]  timer;
   logic [TOW-1:0] tcnt;
   logic [1:0]     ncnt;
   logic [6:0]     acc;
   logic [6:0]     suma;
   logic [4:0]     prom;
   logic           vent;
   logic           alarma;
   logic           err;
   logic [1:0]     est;
   logic           alarma_n;
   logic           vent_n;

   assign suma = acc + {2'b00, bus.temperatura};

   assign bus.lect           = (estado == LECTURA);
   assign bus.en_m1          = (estado != REPOSO);
   assign bus.temp_prom      = prom;
   assign bus.est_ventilador = vent;
   assign bus.est_alarma     = alarma;
   assign bus.err_sensor     = err;
   assign bus.estados        = est;

   // Hysteresis decision on the latched average; fan follows the new alarm state.
   always_comb begin
      alarma_n = alarma;
      if (prom >= A_ON)
         alarma_n = 1'b1;
      else if (prom < A_OFF)
         alarma_n = 1'b0;
      vent_n = vent;
      if (prom >= V_ON || alarma_n)
         vent_n = 1'b1;
      else if (prom < V_OFF)
         vent_n = 1'b0;
   end

   // Sequencer: wait period, read with watchdog, accumulate, evaluate.
   always_ff @(posedge clock) begin
      if (!reset) begin
         estado <= REPOSO;
         timer  <= '0;
         tcnt   <= '0;
         ncnt   <= '0;
         acc    <= '0;
         prom   <= '0;
         vent   <= 1'b0;
         alarma <= 1'b0;
         err    <= 1'b0;
         est    <= 2'b00;
      end else if (!bus.en_sist) begin
         // Disable drops everything except the last average.
         estado <= REPOSO;
         timer  <= '0;
         tcnt   <= '0;
         ncnt   <= '0;
         acc    <= '0;
         vent   <= 1'b0;
         alarma <= 1'b0;
         err    <= 1'b0;
         est    <= 2'b00;
      end else begin
         case (estado)
            REPOSO: begin
               vent   <= 1'b0;
               alarma <= 1'b0;
               err    <= 1'b0;
               est    <= 2'b00;
               timer  <= '0;
               estado <= ESPERA;
            end
            ESPERA: begin
               if (timer == T_FIN) begin
                  timer  <= '0;
                  tcnt   <= '0;
                  estado <= LECTURA;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            LECTURA: begin
               // A sample arriving on the last watchdog cycle still counts.
               if (bus.temp_valida) begin
                  tcnt <= '0;
                  if (ncnt == 2'd3) begin
                     prom   <= 5'(suma >> 2);
                     acc    <= '0;
                     ncnt   <= '0;
                     estado <= EVALUA;
                  end else begin
                     acc    <= suma;
                     ncnt   <= ncnt + 1'b1;
                     estado <= ESPERA;
                  end
               end else if (tcnt == TO_FIN) begin
                  tcnt   <= '0;
                  acc    <= '0;
                  ncnt   <= '0;
                  vent   <= 1'b1;
                  alarma <= 1'b1;
                  err    <= 1'b1;
                  est    <= 2'b11;
                  estado <= ESPERA;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            EVALUA: begin
               vent   <= vent_n;
               alarma <= alarma_n;
               err    <= 1'b0;
               est    <= alarma_n ? 2'b10 : (vent_n ? 2'b01 : 2'b00);
               estado <= ESPERA;
            end
            default: estado <= REPOSO;
         endcase
      end
   end

endmodule

// File: tb/tb_control_temperatura.sv
// Randomized bench for control_temperatura acting as the measurement unit.
// Latency: checks temp_prom one edge and est_*/estados two edges after the 4th sample.
// Backpressure: answers lect after a random delay, or never, to exercise the watchdog.
module tb_control_temperatura;

   localparam int PER   = 16;
   localparam int TO    = 8;
   localparam int V_ON  = 20;
   localparam int A_ON  = 28;
   localparam int HIST  = 2;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   control_temperatura_if ifc ();

   control_temperatura dut (
      .clock (clock),
      .reset (reset),
      .bus   (ifc)
   );

   int total = 0;
   int bad   = 0;

   // Reference state: samples of the current group and the thermal decision.
   int win[$];
   int m_prom  = 0;
   int m_fan   = 0;
   int m_alarm = 0;
   int m_err   = 0;
   int next_gap = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   function automatic int m_estados();
      if (m_err != 0) return 3;
      if (m_alarm != 0) return 2;
      if (m_fan != 0) return 1;
      return 0;
   endfunction

   task automatic model_eval();
      if (m_prom >= A_ON) m_alarm = 1;
      else if (m_prom < A_ON - HIST) m_alarm = 0;
      if (m_prom >= V_ON || m_alarm != 0) m_fan = 1;
      else if (m_prom < V_ON - HIST) m_fan = 0;
      m_err = 0;
   endtask

   task automatic check_outs(input string tag);
      check({tag, ".prom"},  ifc.temp_prom,      m_prom);
      check({tag, ".fan"},   ifc.est_ventilador, m_fan);
      check({tag, ".alarm"}, ifc.est_alarma,     m_alarm);
      check({tag, ".err"},   ifc.err_sensor,     m_err);
      check({tag, ".est"},   ifc.estados,        m_estados());
   endtask

   // Waits for lect, optionally throwing spurious temp_valida pulses meanwhile.
   task automatic wait_lect(input bit spur, output int g);
      g = 0;
      while (!ifc.lect && g < 200) begin
         if (spur && $urandom_range(0, 3) == 0) begin
            ifc.temp_valida = 1'b1;
            ifc.temperatura = 5'($urandom);
         end
         tick();
         ifc.temp_valida = 1'b0;
         g++;
      end
      if (!ifc.lect) check("lect_wait", ifc.lect, 1);
   endtask

   task automatic do_read(input int s, input int d, input bit spur);
      int g;
      int sum;
      wait_lect(spur, g);
      check("gap", g, next_gap);
      check("en_m1", ifc.en_m1, 1);
      for (int i = 0; i < d; i++) begin
         tick();
         check("lect_hold", ifc.lect, 1);
      end
      ifc.temperatura = 5'(s);
      ifc.temp_valida = 1'b1;
      tick();
      ifc.temp_valida = 1'b0;
      ifc.temperatura = 5'($urandom);
      check("lect_drop", ifc.lect, 0);
      win.push_back(s);
      if (win.size() == 4) begin
         sum = 0;
         foreach (win[i]) sum += win[i];
         m_prom = sum / 4;
         win.delete();
         check("prom_n1", ifc.temp_prom, m_prom);
         check("est_n1", ifc.estados, m_estados());
         tick();
         model_eval();
         check_outs("eval");
      end else begin
         check_outs("mid");
      end
      next_gap = PER;
   endtask

   task automatic do_group(input int a, input int b, input int c, input int e, input int d);
      do_read(a, d, 1'b0);
      do_read(b, d, 1'b0);
      do_read(c, d, 1'b0);
      do_read(e, d, 1'b0);
   endtask

   task automatic do_timeout();
      int g;
      wait_lect(1'b0, g);
      check("to_gap", g, next_gap);
      repeat (TO - 1) tick();
      check("to_last", ifc.lect, 1);
      tick();
      check("to_lect", ifc.lect, 0);
      m_err = 1; m_fan = 1; m_alarm = 1;
      win.delete();
      check_outs("timeout");
      next_gap = PER;
   endtask

   initial begin
      int g;
      int base;
      ifc.en_sist     = 1'b1;
      ifc.temperatura = '0;
      ifc.temp_valida = 1'b0;
      reset = 1'b0;
      repeat (3) tick();
      check_outs("reset");
      check("reset.lect", ifc.lect, 0);
      check("reset.en_m1", ifc.en_m1, 0);
      reset = 1'b1;
      next_gap = PER + 1;

      // Directed threshold walk.
      do_group(22, 22, 22, 22, 1);
      do_group(20, 21, 22, 23, 1);
      do_group(19, 19, 19, 19, 1);
      do_group(17, 17, 17, 17, 1);
      do_group(30, 30, 30, 30, 1);
      do_group(27, 27, 27, 27, 1);
      do_group(25, 25, 25, 25, 1);
      do_timeout();
      do_group(10, 10, 10, 10, 1);

      // Random groups around the thresholds, delays up to the last watchdog cycle.
      for (int k = 0; k < 14; k++) begin
         base = $urandom_range(12, 28);
         for (int j = 0; j < 4; j++)
            do_read((base + $urandom_range(0, 3)) % 32, $urandom_range(0, TO - 1), 1'b1);
      end

      // Watchdog in the middle of a group discards the partial sum.
      do_read(31, 0, 1'b1);
      do_read(31, 3, 1'b1);
      do_timeout();
      do_group(5, 6, 7, 8, 7);

      // Disable while reading.
      wait_lect(1'b0, g);
      check("dis_gap", g, next_gap);
      tick();
      ifc.en_sist = 1'b0;
      tick();
      m_fan = 0; m_alarm = 0; m_err = 0;
      win.delete();
      check("dis.lect", ifc.lect, 0);
      check("dis.en_m1", ifc.en_m1, 0);
      check_outs("disable");
      repeat (4) tick();
      check("dis.idle", ifc.en_m1, 0);
      ifc.en_sist = 1'b1;
      next_gap = PER + 1;
      do_group(24, 24, 24, 24, 2);

      // Reset in the middle of a read.
      wait_lect(1'b0, g);
      check("rst_gap", g, next_gap);
      reset = 1'b0;
      tick();
      m_prom = 0; m_fan = 0; m_alarm = 0; m_err = 0;
      win.delete();
      check("rst.lect", ifc.lect, 0);
      check_outs("rst_mid");
      repeat (2) tick();
      reset = 1'b1;
      next_gap = PER + 1;
      do_group(29, 29, 29, 29, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
